frame_tick_scheduler: RTL and testbench

- Sits directly downstream of `rate_divider`.
- Samples the divided square wave from `rate_divider` and converts each rising edge into a single frame-start request to the ray-tracing render core, using a req/ack/done handshake.
- Supports rendering on every Nth tick.
- Counts issued frames and ticks dropped because the renderer was still busy.

---
 rtl/frame_tick_scheduler.sv | 122 ++++++++++++
 tb/tb_frame_tick_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_tick_scheduler.sv
// Frame tick scheduler: turns rising edges of the divided tick wave into
// frame-start requests for the render core (req/ack/done handshake), with
// every-Nth-tick decimation, frame id tracking and a saturating drop counter.
module frame_tick_scheduler #(
  parameter int unsigned SKIP_N  = 1,
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned DROP_W  = 8
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               tick_in,
  input  logic               enable,
  output logic               frame_req,
  input  logic               frame_ack,
  input  logic               frame_done,
  output logic [FRAME_W-1:0] frame_id,
  output logic               busy,
  output logic [DROP_W-1:0]  drop_count
);

  // Last value of the decimation counter before it wraps (SKIP_N is 1..255).
  localparam logic [7:0] SkipLast = 8'(SKIP_N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBusy
  } state_e;

  state_e             state_q, state_d;
  logic               s1_q, s2_q, s3_q;
  logic [7:0]         skip_cnt_q, skip_cnt_d;
  logic [FRAME_W-1:0] frame_id_q, frame_id_d;
  logic [DROP_W-1:0]  drop_count_q, drop_count_d;

  logic tick_evt;
  logic qual;
  logic fire;
  logic drop;

  // Rising-edge detect on the synchronised tick, then decimation by SKIP_N.
  always_comb begin
    tick_evt   = s2_q & ~s3_q;
    qual       = tick_evt & enable;
    fire       = qual & (skip_cnt_q == SkipLast);
    skip_cnt_d = skip_cnt_q;
    if (qual) begin
      skip_cnt_d = fire ? 8'd0 : skip_cnt_q + 8'd1;
    end
  end

  // Handshake FSM next state, frame id advance and drop detection.
  always_comb begin
    state_d    = state_q;
    frame_id_d = frame_id_q;
    drop       = 1'b0;
    case (state_q)
      StIdle: begin
        if (fire) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (frame_ack) begin
          state_d    = StBusy;
          frame_id_d = frame_id_q + FRAME_W'(1);
        end
        // The pending request is still unaccepted, so a new fire is lost.
        if (fire) begin
          drop = 1'b1;
        end
      end
      StBusy: begin
        if (frame_done) begin
          // A fire coinciding with done is served immediately, not dropped.
          state_d = fire ? StReq : StIdle;
        end else if (fire) begin
          drop = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating drop counter next value.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != {DROP_W{1'b1}})) begin
      drop_count_d = drop_count_q + DROP_W'(1);
    end
  end

  // All state: three-flop tick synchroniser, skip counter, FSM, id and drops.
  always_ff @(posedge clkin) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      skip_cnt_q   <= 8'd0;
      state_q      <= StIdle;
      frame_id_q   <= '0;
      drop_count_q <= '0;
    end else begin
      s1_q         <= tick_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      skip_cnt_q   <= skip_cnt_d;
      state_q      <= state_d;
      frame_id_q   <= frame_id_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free.
  always_comb begin
    frame_req  = (state_q == StReq);
    busy       = (state_q != StIdle);
    frame_id   = frame_id_q;
    drop_count = drop_count_q;
  end

endmodule

// File: tb/tb_frame_tick_scheduler.sv
// Self-checking bench for frame_tick_scheduler. Three instances share the
// stimulus; each test resets all of them and checks only the relevant one.
module tb_frame_tick_scheduler;

  logic clk = 1'b0;
  logic reset, tick, en, ack, done;

  logic        req_a, busy_a, req_b, busy_b, req_c, busy_c;
  logic [15:0] id_a, id_b;
  logic [7:0]  drop_a, drop_b;
  logic [1:0]  id_c, drop_c;

  int checks = 0;
  int errors = 0;
  logic seen_b;

  always #10 clk = ~clk;

  frame_tick_scheduler #(.SKIP_N(1), .FRAME_W(16), .DROP_W(8)) dut_a (
    .clkin(clk), .reset(reset), .tick_in(tick), .enable(en), .frame_req(req_a),
    .frame_ack(ack), .frame_done(done), .frame_id(id_a), .busy(busy_a), .drop_count(drop_a)
  );

  frame_tick_scheduler #(.SKIP_N(3), .FRAME_W(16), .DROP_W(8)) dut_b (
    .clkin(clk), .reset(reset), .tick_in(tick), .enable(en), .frame_req(req_b),
    .frame_ack(ack), .frame_done(done), .frame_id(id_b), .busy(busy_b), .drop_count(drop_b)
  );

  frame_tick_scheduler #(.SKIP_N(1), .FRAME_W(2), .DROP_W(2)) dut_c (
    .clkin(clk), .reset(reset), .tick_in(tick), .enable(en), .frame_req(req_c),
    .frame_ack(ack), .frame_done(done), .frame_id(id_c), .busy(busy_c), .drop_count(drop_c)
  );

  typedef struct {
    logic        tick;
    logic        ack;
    logic        done;
    logic        req;
    logic        busy;
    logic [15:0] id;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    if (req_b) seen_b = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; en = 1'b1; ack = 1'b0; done = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic pulse();
    tick = 1'b1;
    repeat (4) step();
    tick = 1'b0;
    repeat (4) step();
  endtask

  // Renderer model for dut_b: ack as soon as req is seen, done three cycles into BUSY.
  int wait_cnt = 0;
  int nreq = 0;
  task automatic cycle_b(input int t);
    logic prev;
    ack  = req_b;
    done = 1'b0;
    if (busy_b && !req_b) begin
      wait_cnt++;
      if (wait_cnt == 3) done = 1'b1;
    end else begin
      wait_cnt = 0;
    end
    prev = req_b;
    step();
    if (req_b && !prev) begin
      nreq++;
      if (nreq == 1) check("skip_first_req_tick", t, 3);
      else if (nreq == 2) check("skip_second_req_tick", t, 6);
    end
  endtask

  initial begin
    logic [1:0] exp_drop[5];

    // Tests 1 and 4 on dut_a: launch timing, handshake, and done coinciding with fire.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3};

    seen_b = 1'b0;
    do_reset();
    check("reset_req", 32'(req_a), 0);
    check("reset_busy", 32'(busy_a), 0);
    check("reset_id", 32'(id_a), 0);
    check("reset_drop", 32'(drop_a), 0);

    for (int k = 0; k < 17; k++) begin
      tick = vecs[k].tick; ack = vecs[k].ack; done = vecs[k].done;
      step();
      check($sformatf("vec%0d_req", k), 32'(req_a), 32'(vecs[k].req));
      check($sformatf("vec%0d_busy", k), 32'(busy_a), 32'(vecs[k].busy));
      check($sformatf("vec%0d_id", k), 32'(id_a), 32'(vecs[k].id));
      check($sformatf("vec%0d_drop", k), 32'(drop_a), 0);
    end

    // Test 2: SKIP_N=3, seven ticks, renderer answers promptly.
    do_reset();
    for (int t = 1; t <= 7; t++) begin
      tick = 1'b1;
      repeat (6) cycle_b(t);
      tick = 1'b0;
      repeat (6) cycle_b(t);
    end
    ack = 1'b0; done = 1'b0;
    check("skip_req_count", 32'(nreq), 2);
    check("skip_final_id", 32'(id_b), 2);
    check("skip_drop", 32'(drop_b), 0);
    check("skip_idle", 32'(busy_b), 0);

    // Test 3: DROP_W=2, first tick launches, renderer never finishes.
    exp_drop[0] = 2'd0; exp_drop[1] = 2'd1; exp_drop[2] = 2'd2;
    exp_drop[3] = 2'd3; exp_drop[4] = 2'd3;
    do_reset();
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse();
      check($sformatf("drop_tick%0d_count", i), 32'(drop_c), 32'(exp_drop[i]));
      check($sformatf("drop_tick%0d_busy", i), 32'(busy_c), 1);
      check($sformatf("drop_tick%0d_req", i), 32'(req_c), 0);
    end
    ack = 1'b0;

    // Test 5a: ticks while disabled neither request nor advance the skip counter.
    do_reset();
    seen_b = 1'b0;
    pulse();
    en = 1'b0;
    pulse();
    pulse();
    check("disabled_no_req", 32'(seen_b), 0);
    en = 1'b1;
    pulse();
    check("skip_held_no_req", 32'(seen_b), 0);
    pulse();
    check("skip_held_req_third", 32'(seen_b), 1);

    // Test 6 (dut_c wrap) alongside dut_a building up to frame_id=5 for test 5b.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      tick = 1'b1;
      repeat (3) step();
      check($sformatf("wrap_f%0d_req", f), 32'(req_c), 1);
      check($sformatf("wrap_f%0d_id", f), 32'(id_c), 32'(f % 4));
      ack = 1'b1; step();
      ack = 1'b0; done = 1'b1; step();
      done = 1'b0; tick = 1'b0;
      repeat (3) step();
    end
    tick = 1'b1;
    repeat (3) step();
    check("pre_reset_req", 32'(req_a), 1);
    check("pre_reset_id", 32'(id_a), 5);
    tick = 1'b0;
    repeat (3) step();
    tick = 1'b1;
    repeat (3) step();
    check("pre_reset_drop", 32'(drop_a), 1);

    // Test 5b: reset while in REQ abandons the handshake.
    reset = 1'b1;
    step();
    check("midreset_req", 32'(req_a), 0);
    check("midreset_busy", 32'(busy_a), 0);
    check("midreset_id", 32'(id_a), 0);
    check("midreset_drop", 32'(drop_a), 0);
    reset = 1'b0;
    tick = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
